bus_bridge: RTL and testbench
=============================

BUS_BRIDGE -- requirements
Module: bus_bridge

Interface
REQ-001 SHALL have parameter DRAM_AW, default 14, meaning DRAM word-address width.
REQ-002 SHALL have parameter SCAN_DIV, default 20000, meaning clk cycles per display digit.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_addr  in  32  CPU data byte address (CPU MEM-stage ALU result).
REQ-006 SHALL have port cpu_we  in  1  CPU store strobe.
REQ-007 SHALL have port cpu_wdata  in  32  CPU store data.
REQ-008 SHALL have port cpu_rdata  out  32  load data returned to CPU, same cycle.
REQ-009 SHALL have ports dram_addr out DRAM_AW, dram_we out 1, dram_wdata out 32, dram_rdata in 32 (async-read, sync-write RAM).
REQ-010 SHALL have ports sw in 24 (switches), led out 24, dig_en out 8 (active-low digit enables), dig_seg out 8 (active-low {DP,g,f,e,d,c,b,a}).

Function
REQ-011 SHALL decode the peripheral map: 0xFFFF_F000 display register (R/W), 0xFFFF_F020 timer (R/W), 0xFFFF_F060 LED register (R/W), 0xFFFF_F070 switches (R only); any other address in 0xFFFF_F000-0xFFFF_FFFF is unmapped; all remaining addresses are DRAM.
REQ-012 SHALL drive dram_addr = cpu_addr[DRAM_AW+1:2], dram_wdata = cpu_wdata, dram_we = cpu_we AND DRAM region, all combinational.
REQ-013 SHALL drive cpu_rdata combinationally: DRAM -> dram_rdata; display/LED/timer -> current register value; switches -> {8'h00, sw_sync}; unmapped -> 0.
REQ-014 SHALL update a peripheral register on the rising edge where cpu_we=1 and its address is selected; same-cycle reads return the pre-write value.
REQ-015 SHALL ignore writes to the switch address and to unmapped addresses (no state change, dram_we=0).
REQ-016 SHALL pass sw through a two-flop synchronizer; an sw change is visible on cpu_rdata 2 cycles later.
REQ-017 SHALL drive led = LED register [23:0]; led register bits [31:24] read back 0.
REQ-018 SHALL increment the 32-bit timer every cycle, wrapping 0xFFFF_FFFF -> 0; a CPU write loads cpu_wdata (write wins over increment), increment resumes the next cycle.
REQ-019 SHALL run a divider counting 0..SCAN_DIV-1; at SCAN_DIV-1 it returns to 0 and the 3-bit digit index advances, wrapping 7 -> 0.
REQ-020 SHALL drive dig_en with bit[index]=0 and all other bits 1.
REQ-021 SHALL drive dig_seg[6:0] as the active-low hex glyph of display[4*index+3 : 4*index] (0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110) and dig_seg[7]=1.
REQ-022 SHALL decode dig_en/dig_seg combinationally from registered index and display register (display write visible on the edge it is captured).

Reset
REQ-023 SHALL, while rst_n=0, hold display=0, led register=0, timer=0, divider=0, index=0, synchronizer flops=0, giving led=0, dig_en=8'hFE, dig_seg=8'hC0.
REQ-024 SHALL, on reset assertion mid-scan or mid-write, clear all state immediately, regardless of clk.
REQ-025 SHALL resume counting on the first rising edge after rst_n deasserts (timer reads 1 one cycle after release).

Structure
REQ-026 SHALL place peripheral address constants, SCAN_DIV default and the 16-entry glyph table in shared package bridge_pkg.
REQ-027 SHALL implement divider, digit index and glyph decode in one sub-module seg7_scan; decode, registers, timer and synchronizer stay in bus_bridge.

Verification
REQ-028 SHALL test DRAM pass-through: store 0xDEAD_BEEF to 0x0000_0104 -> dram_we=1, dram_addr=0x041; load 0x104 -> cpu_rdata=dram_rdata.
REQ-029 SHALL test LED: store 0xFF12_3456 to 0xFFFF_F060 -> led=0x123456 next cycle; readback 0x0012_3456; dram_we stays 0.
REQ-030 SHALL test switches: sw=0xABCDEF at cycle N -> read 0xFFFF_F070 returns 0x00AB_CDEF from cycle N+2, old value at N+1.
REQ-031 SHALL test timer: store 0xFFFF_FFFE -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on successive cycles.
REQ-032 SHALL test scan with SCAN_DIV=4: display=0x8765_43F0 -> dig_en steps FE,FD,FB,.. every 4 cycles; digit0 seg 0xC0, digit1 seg 0x8E, digit7 seg 0x80; wraps to FE after 32 cycles.
REQ-033 SHALL test async reset mid-scan (index 5, timer nonzero) -> outputs return to reset values (dig_en=FE, dig_seg=C0, led=0) without a clock edge.

Source files
------------

// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_pkg
//  Description : Shared constants for the CPU bus bridge: peripheral address
//                map, default display scan divider and the 7-segment glyphs.
//  Revision    : 1.0 - initial release
// ============================================================================
package bridge_pkg;

    // Upper 20 address bits that identify the peripheral page
    localparam logic [19:0] C_PERIPH_PAGE   = 20'hFFFFF;

    localparam logic [31:0] C_ADDR_DISPLAY  = 32'hFFFF_F000;
    localparam logic [31:0] C_ADDR_TIMER    = 32'hFFFF_F020;
    localparam logic [31:0] C_ADDR_LED      = 32'hFFFF_F060;
    localparam logic [31:0] C_ADDR_SWITCH   = 32'hFFFF_F070;

    localparam int          C_SCAN_DIV_DEFAULT = 20000;

    // Active-low {g,f,e,d,c,b,a} glyphs, indexed by hex digit value
    localparam logic [15:0][6:0] C_GLYPH = {
        7'b0001110,   // F
        7'b0000110,   // E
        7'b0100001,   // d
        7'b1000110,   // C
        7'b0000011,   // b
        7'b0001000,   // A
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

endpackage
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan
//  Description : Multiplexed 8-digit 7-segment driver. A divider paces the
//                digit index; enables and segments decode combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan
    import bridge_pkg::*;
#(
    parameter int SCAN_DIV = C_SCAN_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] display,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    // A one-cycle divider still needs a one-bit counter
    localparam int C_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(SCAN_DIV - 1);

    logic [C_DIV_W-1:0] r_div;
    logic [2:0]         r_idx;
    logic [3:0]         w_nibble;

    // Divider wraps at SCAN_DIV-1 and advances the digit index on the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == C_DIV_LAST) begin
            r_div <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_div <= r_div + C_DIV_W'(1);
        end
    end

    // Select the active digit and look up its glyph; DP stays dark
    always_comb begin
        w_nibble = display[4*r_idx +: 4];
        dig_en   = ~(8'b0000_0001 << r_idx);
        dig_seg  = {1'b1, C_GLYPH[w_nibble]};
    end

endmodule
`default_nettype wire

// File: rtl/bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : bus_bridge
//  Description : CPU data-bus bridge. Routes accesses to DRAM or to the
//                display, timer, LED and switch peripherals.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_bridge
    import bridge_pkg::*;
#(
    parameter int DRAM_AW  = 14,
    parameter int SCAN_DIV = C_SCAN_DIV_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        cpu_addr,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         dig_seg
);

    logic        w_periph;
    logic        w_sel_disp;
    logic        w_sel_timer;
    logic        w_sel_led;
    logic        w_sel_sw;

    logic [31:0] r_display;
    logic [31:0] r_timer;
    logic [23:0] r_led;
    logic [23:0] r_sw_meta;
    logic [23:0] r_sw_sync;

    // Address decode; anything outside the peripheral page is DRAM
    always_comb begin
        w_periph    = (cpu_addr[31:12] == C_PERIPH_PAGE);
        w_sel_disp  = (cpu_addr == C_ADDR_DISPLAY);
        w_sel_timer = (cpu_addr == C_ADDR_TIMER);
        w_sel_led   = (cpu_addr == C_ADDR_LED);
        w_sel_sw    = (cpu_addr == C_ADDR_SWITCH);
    end

    // DRAM sees the word address directly; stores only in the DRAM region
    always_comb begin
        dram_addr  = cpu_addr[DRAM_AW+1:2];
        dram_wdata = cpu_wdata;
        dram_we    = cpu_we & ~w_periph;
    end

    // Load mux; the switch and unmapped addresses are never writable
    always_comb begin
        cpu_rdata = '0;
        if (!w_periph)        cpu_rdata = dram_rdata;
        else if (w_sel_disp)  cpu_rdata = r_display;
        else if (w_sel_timer) cpu_rdata = r_timer;
        else if (w_sel_led)   cpu_rdata = {8'h00, r_led};
        else if (w_sel_sw)    cpu_rdata = {8'h00, r_sw_sync};
    end

    // Display and LED registers capture CPU stores to their addresses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_display <= '0;
            r_led     <= '0;
        end else begin
            if (cpu_we && w_sel_disp) r_display <= cpu_wdata;
            if (cpu_we && w_sel_led)  r_led     <= cpu_wdata[23:0];
        end
    end

    // Free-running timer; a CPU store takes priority over the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_timer <= '0;
        else if (cpu_we && w_sel_timer) r_timer <= cpu_wdata;
        else                           r_timer <= r_timer + 32'd1;
    end

    // Two-flop synchronizer for the asynchronous switch inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    // LED pins mirror the LED register
    always_comb led = r_led;

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .display (r_display),
        .dig_en  (dig_en),
        .dig_seg (dig_seg)
    );

endmodule
`default_nettype wire

// File: tb/tb_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_bridge
//  Description : Directed self-checking bench for bus_bridge with a small
//                DRAM model and an expected-value queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_bridge;

    localparam int C_AW = 14;

    logic            clk;
    logic            rst_n;
    logic [31:0]     cpu_addr;
    logic            cpu_we;
    logic [31:0]     cpu_wdata;
    logic [31:0]     cpu_rdata;
    logic [C_AW-1:0] dram_addr;
    logic            dram_we;
    logic [31:0]     dram_wdata;
    logic [31:0]     dram_rdata;
    logic [23:0]     sw;
    logic [23:0]     led;
    logic [7:0]      dig_en;
    logic [7:0]      dig_seg;

    logic [31:0]     mem [0:255];
    string           tag_q[$];
    logic [31:0]     exp_q[$];
    int              n_checks;
    int              n_errors;

    bus_bridge #(
        .DRAM_AW  (C_AW),
        .SCAN_DIV (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .led        (led),
        .dig_en     (dig_en),
        .dig_seg    (dig_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small async-read, sync-write RAM model
    assign dram_rdata = mem[dram_addr[7:0]];
    always @(posedge clk) if (dram_we) mem[dram_addr[7:0]] <= dram_wdata;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;  4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;  4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    task automatic push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: observed=%h expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_errors++;
                $error("FAIL %s: observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          idx;
        logic [31:0] disp;
        n_checks  = 0;
        n_errors  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n     = 1'b0;
        cpu_addr  = 32'hFFFF_F020;
        cpu_we    = 1'b0;
        cpu_wdata = 32'h0;
        sw        = 24'h0;
        #12;

        // Reset state
        push("rst_led", 32'h0);        check({8'h0, led});
        push("rst_dig_en", 32'hFE);    check({24'h0, dig_en});
        push("rst_dig_seg", 32'hC0);   check({24'h0, dig_seg});
        push("rst_timer", 32'h0);      check(cpu_rdata);

        // First edge after release counts the timer to 1
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        push("timer_after_release", 32'h1); check(cpu_rdata);

        // DRAM pass-through
        cpu_addr = 32'h0000_0104; cpu_we = 1'b1; cpu_wdata = 32'hDEAD_BEEF;
        #1;
        push("dram_we", 32'h1);          check({31'h0, dram_we});
        push("dram_addr", 32'h41);       check({18'h0, dram_addr});
        push("dram_wdata", 32'hDEADBEEF); check(dram_wdata);
        tick();
        cpu_we = 1'b0;
        #1;
        push("dram_load", 32'hDEADBEEF); check(cpu_rdata);

        // LED register: same-cycle read returns the old value
        cpu_addr = 32'hFFFF_F060; cpu_we = 1'b1; cpu_wdata = 32'hFF12_3456;
        #1;
        push("led_dram_we", 32'h0);      check({31'h0, dram_we});
        push("led_prewrite", 32'h0);     check(cpu_rdata);
        tick();
        cpu_we = 1'b0;
        #1;
        push("led_pins", 32'h123456);    check({8'h0, led});
        push("led_readback", 32'h0012_3456); check(cpu_rdata);

        // Switch synchronizer latency
        cpu_addr = 32'hFFFF_F070;
        sw = 24'hABCDEF;
        #1;
        push("sw_n0", 32'h0);            check(cpu_rdata);
        tick();
        push("sw_n1", 32'h0);            check(cpu_rdata);
        tick();
        push("sw_n2", 32'h00AB_CDEF);    check(cpu_rdata);

        // Writes to the switch and unmapped addresses are dropped
        cpu_we = 1'b1; cpu_wdata = 32'h1234_5678;
        #1;
        push("sw_write_dram_we", 32'h0); check({31'h0, dram_we});
        tick();
        push("sw_write_ignored", 32'h00AB_CDEF); check(cpu_rdata);
        cpu_addr = 32'hFFFF_F100;
        #1;
        push("unmapped_dram_we", 32'h0); check({31'h0, dram_we});
        tick();
        cpu_we = 1'b0;
        #1;
        push("unmapped_read", 32'h0);    check(cpu_rdata);

        // Timer load and wrap
        cpu_addr = 32'hFFFF_F020; cpu_we = 1'b1; cpu_wdata = 32'hFFFF_FFFE;
        tick();
        cpu_we = 1'b0;
        #1;
        push("timer_load", 32'hFFFF_FFFE); check(cpu_rdata);
        tick();
        push("timer_max", 32'hFFFF_FFFF);  check(cpu_rdata);
        tick();
        push("timer_wrap", 32'h0);         check(cpu_rdata);

        // Fresh reset to align the scan, then load the display
        rst_n = 1'b0;
        #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        disp = 32'h8765_43F0;
        cpu_addr = 32'hFFFF_F000; cpu_we = 1'b1; cpu_wdata = disp;
        for (int k = 1; k <= 53; k++) begin
            tick();
            if (k == 1) begin
                cpu_addr = 32'hFFFF_F060; cpu_wdata = 32'h0000_0055;
            end else if (k == 2) begin
                cpu_we = 1'b0; cpu_addr = 32'hFFFF_F020;
                #1;
                push("scan_led", 32'h55); check({8'h0, led});
            end
            idx = (k / 4) % 8;
            push($sformatf("scan_en_k%0d", k), {24'h0, ~(8'h01 << idx)});
            check({24'h0, dig_en});
            push($sformatf("scan_seg_k%0d", k), {24'h0, 1'b1, glyph(disp[4*idx +: 4])});
            check({24'h0, dig_seg});
        end
        push("timer_midscan", 32'd53);   check(cpu_rdata);

        // Asynchronous reset mid-scan, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        push("arst_dig_en", 32'hFE);     check({24'h0, dig_en});
        push("arst_dig_seg", 32'hC0);    check({24'h0, dig_seg});
        push("arst_led", 32'h0);         check({8'h0, led});
        push("arst_timer", 32'h0);       check(cpu_rdata);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
